c_demux3_5b_cache_sync: RTL
===========================

Name: c_demux3_5b_cache_sync

Overview:
- Distribution end of the cache-side 3-way merge path.
- Takes the single merged token stream, normally from the FIFO behind the merge, plus a 2-bit destination tag.
- Routes each 5-bit token to one of three consumer channels, using the codebase's drive/free pulse handshake on every port.
- Synchronous, single clock. One input holding slot and one in-flight token per output channel.

Parameters:
DATA_W, 5, payload width per token
CNT_W, 8, width of per-channel token counters (used only with the optional feature)

Ports:
clk  in  1  clock; all logic on the rising edge
rstn  in  1  asynchronous active-low reset
i_drive  in  1  one-cycle pulse: upstream token valid this cycle
i_data  in  DATA_W  token payload, sampled when i_drive=1
i_sel  in  2  destination 0..2; 3 is illegal; sampled when i_drive=1
o_free  out  1  one-cycle pulse: input token consumed, upstream may drive again
o_drive0/1/2  out  1  one-cycle pulse: token issued to channel k
o_data0/1/2  out  DATA_W  channel k payload, held stable from o_drivek until the channel is freed
i_free0/1/2  in  1  one-cycle pulse: consumer k has taken the token
o_err  out  2  sticky: bit0 = illegal sel, bit1 = overrun
o_cnt0/1/2  out  CNT_W  tokens delivered per channel (optional feature)

Behaviour:
- Reset (rstn=0, async): input slot EMPTY; all channels IDLE.
  - o_free=0, o_drivek=0, o_datak=0, o_err=0, o_cntk=0.
  - Reset mid-transaction discards slot and in-flight tokens. No o_free or o_drive is issued for them.
- Input slot FSM (EMPTY/FULL):
  - EMPTY & i_drive: capture {i_sel, i_data}, go FULL.
  - FULL: dispatch when the target channel is IDLE.
  - Dispatch cycle d: o_drive[sel]=1, o_data[sel] loaded, o_free=1.
  - Slot returns EMPTY at the end of d, unless i_drive is also high in d. In that case the new token is captured and the slot stays FULL (back-to-back, no bubble).
- Latency: i_drive in cycle t with the target channel IDLE gives o_drivek and o_free both in cycle t+1. Sustained throughput is one token per cycle while alternating between idle channels.
- Channel FSM, per k (IDLE/BUSY):
  - Dispatch moves the channel to BUSY.
  - i_freek while BUSY moves it to IDLE at the end of that cycle.
  - A slot token waiting on k dispatches in the following cycle, i.e. i_freek at u gives o_drivek at u+1.
- Spurious free: i_freek while IDLE is ignored, with no error.
- Head-of-line blocking: a token for a BUSY channel stalls the slot. Other channels are not served out of order, preserving the single-stream order.
- Illegal sel=3: on dispatch, o_free pulses, no o_drive pulses, token is dropped, and o_err[0] is set.
- Overrun: i_drive while the slot is FULL and not dispatching that cycle.
  - Token is dropped, no o_free, o_err[1] is set.
  - The slot contents are unaffected.
- o_err bits clear only on reset.
- o_datak holds its last value after free. Consumers sample only on o_drivek.

Optional Feature:
CDEMUX_STATS_EN
- Defined:
  - o_cntk increments by 1 in each cycle o_drivek=1.
  - Counters wrap at 2^CNT_W.
  - Illegal and overrun tokens are not counted.
- Undefined: o_cntk tied to 0, counter flops absent. Ports remain, so the interface is stable.

Decomposition:
- Package c_cache_hs_pkg holds:
  - DATA_W default
  - SEL_CH0/1/2, SEL_ILLEGAL=2'd3
  - error bit indices ERR_SEL=0, ERR_OVR=1
  - slot/channel state encodings
- One natural sub-module, c_demux_chan: per-channel IDLE/BUSY FSM, data hold register, drive pulse and optional counter. Instantiated three times.
- The top module holds the input slot, the dispatch arbitration and the error logic.

Test Plan:
- Reset, then i_drive t=2, data=5'h15, sel=1 -> o_drive1 and o_free at t=3, o_data1=5'h15; o_drive0/2 stay 0; o_err=0.
- Back-to-back: sel=0/1/2 on cycles 2,3,4 (data 1,2,3) with all channels idle -> o_drive0/1/2 on cycles 3,4,5 with matching data; o_free on 3,4,5.
- Blocking: token A (sel=0), token B (sel=0) with no i_free0 -> B held, no o_free for B. i_free0 at u -> o_drive0 carries B at u+1.
- Illegal: sel=3, data=5'h1F -> o_free 1 cycle later, no o_drivek, o_err=2'b01 until reset.
- Overrun: slot FULL for a BUSY channel, extra i_drive -> o_err[1]=1, original token still delivered after free. Assert async rstn mid-BUSY -> all outputs 0 immediately.
- With CDEMUX_STATS_EN, CNT_W=8: 258 tokens to channel 2 -> o_cnt2=2; o_cnt0=o_cnt1=0.

Source files
------------

// File: rtl/c_cache_hs_pkg.sv
// Shared handshake constants and state encodings for the cache-side merge/demux path.
package c_cache_hs_pkg;

  localparam int unsigned DATA_W_DEFAULT = 5;

  localparam logic [1:0] SEL_CH0     = 2'd0;
  localparam logic [1:0] SEL_CH1     = 2'd1;
  localparam logic [1:0] SEL_CH2     = 2'd2;
  localparam logic [1:0] SEL_ILLEGAL = 2'd3;

  localparam int unsigned ERR_SEL = 0;
  localparam int unsigned ERR_OVR = 1;

  typedef enum logic {SlotEmpty, SlotFull} slot_state_e;
  typedef enum logic {ChIdle, ChBusy} chan_state_e;

endpackage

// File: rtl/c_demux_chan.sv
// One demux output channel: IDLE/BUSY FSM, payload hold register, optional delivery counter.
// Counter present only when CDEMUX_STATS_EN is defined.
module c_demux_chan
  import c_cache_hs_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              drive_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              free_i,
  output logic              busy_o,
  output logic              drive_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CNT_W-1:0]  cnt_o
);

  chan_state_e       state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    unique case (state_q)
      ChIdle: begin
        // A free while idle is spurious and ignored.
        if (drive_i) begin
          state_d = ChBusy;
          data_d  = data_i;
        end
      end
      ChBusy: begin
        if (free_i) state_d = ChIdle;
      end
      default: state_d = ChIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ChIdle;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign busy_o  = (state_q == ChBusy);
  assign drive_o = drive_i;
  // Payload is forwarded in the issue cycle so consumers can sample on the drive pulse.
  assign data_o  = drive_i ? data_i : data_q;

`ifdef CDEMUX_STATS_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (drive_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
`else
  assign cnt_o = '0;
`endif

endmodule

// File: rtl/c_demux3_5b_cache_sync.sv
// 3-way token demux: one input holding slot, head-of-line dispatch, sticky error flags.
// Per-channel counters enabled by CDEMUX_STATS_EN.
module c_demux3_5b_cache_sync
  import c_cache_hs_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_drive,
  input  logic [DATA_W-1:0] i_data,
  input  logic [1:0]        i_sel,
  output logic              o_free,
  output logic              o_drive0,
  output logic              o_drive1,
  output logic              o_drive2,
  output logic [DATA_W-1:0] o_data0,
  output logic [DATA_W-1:0] o_data1,
  output logic [DATA_W-1:0] o_data2,
  input  logic              i_free0,
  input  logic              i_free1,
  input  logic              i_free2,
  output logic [1:0]        o_err,
  output logic [CNT_W-1:0]  o_cnt0,
  output logic [CNT_W-1:0]  o_cnt1,
  output logic [CNT_W-1:0]  o_cnt2
);

  slot_state_e       slot_q, slot_d;
  logic [1:0]        sel_q, sel_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [1:0]        err_q, err_d;

  logic              target_busy;
  logic              dispatch;
  logic              overrun;
  logic [2:0]        chan_busy;
  logic [2:0]        chan_drive_in;
  logic [2:0]        chan_drive_out;
  logic [2:0]        chan_free;
  logic [DATA_W-1:0] chan_data [3];
  logic [CNT_W-1:0]  chan_cnt  [3];

  always_comb begin
    target_busy = 1'b0;
    unique case (sel_q)
      SEL_CH0: target_busy = chan_busy[0];
      SEL_CH1: target_busy = chan_busy[1];
      SEL_CH2: target_busy = chan_busy[2];
      default: target_busy = 1'b0;
    endcase
    // Illegal tokens never wait: they are consumed and dropped.
    dispatch = (slot_q == SlotFull) && !target_busy;
    overrun  = i_drive && (slot_q == SlotFull) && !dispatch;

    chan_drive_in[0] = dispatch && (sel_q == SEL_CH0);
    chan_drive_in[1] = dispatch && (sel_q == SEL_CH1);
    chan_drive_in[2] = dispatch && (sel_q == SEL_CH2);
  end

  always_comb begin
    slot_d = slot_q;
    sel_d  = sel_q;
    data_d = data_q;
    err_d  = err_q;
    unique case (slot_q)
      SlotEmpty: begin
        if (i_drive) begin
          slot_d = SlotFull;
          sel_d  = i_sel;
          data_d = i_data;
        end
      end
      SlotFull: begin
        if (dispatch) begin
          if (i_drive) begin
            sel_d  = i_sel;
            data_d = i_data;
          end else begin
            slot_d = SlotEmpty;
          end
        end
      end
      default: slot_d = SlotEmpty;
    endcase
    if (dispatch && (sel_q == SEL_ILLEGAL)) err_d[ERR_SEL] = 1'b1;
    if (overrun)                            err_d[ERR_OVR] = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      slot_q <= SlotEmpty;
      sel_q  <= SEL_CH0;
      data_q <= '0;
      err_q  <= '0;
    end else begin
      slot_q <= slot_d;
      sel_q  <= sel_d;
      data_q <= data_d;
      err_q  <= err_d;
    end
  end

  assign chan_free = {i_free2, i_free1, i_free0};

  for (genvar k = 0; k < 3; k++) begin : g_chan
    c_demux_chan #(
      .DATA_W(DATA_W),
      .CNT_W (CNT_W)
    ) u_chan (
      .clk_i  (clk),
      .rst_ni (rstn),
      .drive_i(chan_drive_in[k]),
      .data_i (data_q),
      .free_i (chan_free[k]),
      .busy_o (chan_busy[k]),
      .drive_o(chan_drive_out[k]),
      .data_o (chan_data[k]),
      .cnt_o  (chan_cnt[k])
    );
  end

  assign o_free   = dispatch;
  assign o_drive0 = chan_drive_out[0];
  assign o_drive1 = chan_drive_out[1];
  assign o_drive2 = chan_drive_out[2];
  assign o_data0  = chan_data[0];
  assign o_data1  = chan_data[1];
  assign o_data2  = chan_data[2];
  assign o_cnt0   = chan_cnt[0];
  assign o_cnt1   = chan_cnt[1];
  assign o_cnt2   = chan_cnt[2];
  assign o_err    = err_q;

endmodule
